// File: rtl/fb_ahb_write_master.sv
// Frame-buffer write master: buffers pixel words from the transfer engine and
// writes each one to memory as a single-beat AHB-Lite word write.
module fb_ahb_write_master #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          PIXEL_COUNT = 307200,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data,
    input  logic        done,
    output logic        ready_for_data,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        frame_done,
    output logic        error
);
    localparam int CW = $clog2(PIXEL_COUNT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] PC_C = CW'(PIXEL_COUNT);
    localparam logic [PW:0]   FD_C = (PW + 1)'(FIFO_DEPTH);

    // S_IDLE: wait for start | S_RUN: move frame | S_DONE: frame_done pulse | S_ERROR: sticky error
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} state_t;

    state_t          state_q;
    logic [31:0]     fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic [CW-1:0]   rx_cnt_q, iss_cnt_q, cmp_cnt_q;
    logic            dp_valid_q;
    logic [31:0]     hwdata_q, haddr_last_q;

    logic            push, pop, addr_ph, dp_ok, dp_err, underrun;
    logic [31:0]     addr_cur;

    assign ready_for_data = (state_q == S_RUN) && (count_q < FD_C) && (rx_cnt_q < PC_C);
    assign addr_ph  = (state_q == S_RUN) && (count_q != '0) && (iss_cnt_q < PC_C);
    assign addr_cur = BASE_ADDR + (32'(iss_cnt_q) << 2);
    assign push     = ready_for_data;
    assign pop      = addr_ph && HREADY;
    assign dp_ok    = dp_valid_q && HREADY && !HRESP;
    assign dp_err   = dp_valid_q && HRESP;
    assign underrun = done && (rx_cnt_q < PC_C);

    assign HADDR      = addr_ph ? addr_cur : haddr_last_q;
    assign HTRANS     = addr_ph ? 2'b10 : 2'b00;
    assign HWRITE     = addr_ph;
    assign HSIZE      = 3'b010;
    assign HBURST     = 3'b000;
    assign HWDATA     = hwdata_q;
    assign frame_done = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rx_cnt_q     <= '0;
            iss_cnt_q    <= '0;
            cmp_cnt_q    <= '0;
            dp_valid_q   <= 1'b0;
            hwdata_q     <= '0;
            haddr_last_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hwdata_q <= fifo_q[rd_ptr_q];
            end
            if (addr_ph) haddr_last_q <= addr_cur;
            count_q <= count_d;
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        count_q    <= '0;
                        rx_cnt_q   <= '0;
                        iss_cnt_q  <= '0;
                        cmp_cnt_q  <= '0;
                        dp_valid_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (push)  rx_cnt_q  <= rx_cnt_q + 1'b1;
                    if (pop)   iss_cnt_q <= iss_cnt_q + 1'b1;
                    if (dp_ok) cmp_cnt_q <= cmp_cnt_q + 1'b1;
                    if (pop)         dp_valid_q <= 1'b1;
                    else if (HREADY) dp_valid_q <= 1'b0;
                    // Error drops the pending data phase and everything behind it.
                    if (dp_err || underrun) begin
                        state_q    <= S_ERROR;
                        dp_valid_q <= 1'b0;
                    end else if (cmp_cnt_q == PC_C) begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_ahb_write_master.sv
// Bench for fb_ahb_write_master: frame-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_fb_ahb_write_master;
    localparam int          PC   = 4;
    localparam int          DEP  = 4;
    localparam logic [31:0] BASE = 32'h1000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, done = 1'b0;
    logic [31:0] data = 32'h0;
    logic        HREADY = 1'b1, HRESP = 1'b0;
    logic        ready_for_data, HWRITE, frame_done, error;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;

    int n_cmp = 0, n_fail = 0;

    // frame model: 0 idle, 1 running, 2 done pulse, 3 error
    int  m_st = 0, m_push = 0, m_iss = 0, m_cmp = 0, m_dp_idx = 0;
    bit  m_dp = 0;
    int  obs_acc = 0, obs_fd = 0;
    logic [31:0] obs_addr [$];

    fb_ahb_write_master #(.FIFO_DEPTH(DEP), .PIXEL_COUNT(PC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .done(done),
        .ready_for_data(ready_for_data), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .frame_done(frame_done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Pixel i of every frame is 00AA0001+i; the next word appears after each consuming edge.
    initial forever begin
        @(posedge clk);
        #1 data = 32'h00AA0001 + 32'(m_push);
    end

    always @(negedge clk) begin
        bit exp_rfd, exp_ap, acc, dpok, dperr, und;
        if (rst) begin
            chk("rst_rfd", {31'b0, ready_for_data}, 0);
            chk("rst_htrans", {30'b0, HTRANS}, 0);
            chk("rst_hwrite", {31'b0, HWRITE}, 0);
            chk("rst_haddr", HADDR, 0);
            chk("rst_hwdata", HWDATA, 0);
            chk("rst_fdone", {31'b0, frame_done}, 0);
            chk("rst_error", {31'b0, error}, 0);
            chk("rst_hsize", {29'b0, HSIZE}, 32'd2);
            chk("rst_hburst", {29'b0, HBURST}, 0);
            m_st = 0; m_push = 0; m_iss = 0; m_cmp = 0; m_dp = 0;
        end else begin
            exp_rfd = (m_st == 1) && (m_push - m_iss < DEP) && (m_push < PC);
            exp_ap  = (m_st == 1) && (m_push > m_iss) && (m_iss < PC);
            chk("rfd", {31'b0, ready_for_data}, {31'b0, exp_rfd});
            chk("htrans", {30'b0, HTRANS}, exp_ap ? 32'd2 : 32'd0);
            chk("hwrite", {31'b0, HWRITE}, {31'b0, exp_ap});
            if (exp_ap) chk("haddr", HADDR, BASE + 32'(4 * m_iss));
            if (m_dp) chk("hwdata", HWDATA, 32'h00AA0001 + 32'(m_dp_idx));
            chk("frame_done", {31'b0, frame_done}, {31'b0, m_st == 2});
            chk("error", {31'b0, error}, {31'b0, m_st == 3});
            chk("hsize", {29'b0, HSIZE}, 32'd2);
            chk("hburst", {29'b0, HBURST}, 0);
            if (HTRANS == 2'b10 && HREADY) begin
                obs_acc++;
                obs_addr.push_back(HADDR);
            end
            if (frame_done) obs_fd++;
            case (m_st)
                0, 3: if (start) begin
                    m_st = 1; m_push = 0; m_iss = 0; m_cmp = 0; m_dp = 0;
                end
                2: m_st = 0;
                default: begin
                    acc   = exp_ap && HREADY;
                    dpok  = m_dp && HREADY && !HRESP;
                    dperr = m_dp && HRESP;
                    und   = done && (m_push < PC);
                    if (dperr || und) begin
                        m_st = 3; m_dp = 0;
                    end else begin
                        if (m_cmp == PC) m_st = 2;
                        if (dpok) m_cmp++;
                        if (acc) begin m_dp = 1; m_dp_idx = m_iss; end
                        else if (HREADY) m_dp = 0;
                    end
                    if (exp_rfd) m_push++;
                    if (acc) m_iss++;
                end
            endcase
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic clear_obs();
        obs_acc = 0; obs_fd = 0; obs_addr.delete();
    endtask

    // kind: 0 pushes>=val, 1 NONSEQ at address val, 2 accepted>=val, 3 frame_done count>=val
    task automatic wait_evt(input int kind, input int val, input string nm);
        bit hit = 0;
        for (int k = 0; k < 60 && !hit; k++) begin
            case (kind)
                0:       hit = (m_push >= val);
                1:       hit = (HTRANS == 2'b10) && (HADDR == 32'(val));
                2:       hit = (obs_acc >= val);
                default: hit = (obs_fd >= val);
            endcase
            if (!hit) tick();
        end
        n_cmp++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_%s: event not seen within 60 cycles", nm);
        end
    endtask

    task automatic check_full_frame(input string nm);
        chk({nm, "_writes"}, 32'(obs_acc), 32'd4);
        chk({nm, "_fdone_cnt"}, 32'(obs_fd), 32'd1);
        chk({nm, "_addr_cnt"}, 32'(obs_addr.size()), 32'd4);
        for (int i = 0; i < obs_addr.size(); i++)
            chk({nm, "_addr"}, obs_addr[i], 32'h1000 + 32'(4 * i));
    endtask

    initial begin
        bit seen;
        #1;
        // Reset
        tick(3);
        chk("t1_htrans", {30'b0, HTRANS}, 0);
        chk("t1_haddr", HADDR, 0);
        rst = 1'b0;
        tick(3);
        chk("t1_idle_htrans", {30'b0, HTRANS}, 0);

        // Zero-wait frame, with a late done that must be ignored
        clear_obs();
        pulse_start();
        wait_evt(0, 4, "t2_push");
        done = 1'b1; tick(); done = 1'b0;
        wait_evt(3, 1, "t2_fdone");
        tick(3);
        check_full_frame("t2");
        chk("t2_error", {31'b0, error}, 0);
        chk("t2_idle_htrans", {30'b0, HTRANS}, 0);

        // Three wait states on the second data phase, stray start ignored
        clear_obs();
        pulse_start();
        wait_evt(1, 32'h1008, "t3_addr");
        HREADY = 1'b0;
        tick();
        chk("t3_hwdata", HWDATA, 32'h00AA0002);
        chk("t3_haddr", HADDR, 32'h1008);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_hwdata2", HWDATA, 32'h00AA0002);
        chk("t3_rfd", {31'b0, ready_for_data}, 0);
        tick();
        HREADY = 1'b1;
        wait_evt(3, 1, "t3_fdone");
        tick(3);
        check_full_frame("t3");

        // ERROR response on the third data phase
        clear_obs();
        pulse_start();
        wait_evt(1, 32'h100C, "t4_addr");
        chk("t4_hwdata", HWDATA, 32'h00AA0003);
        HREADY = 1'b0; HRESP = 1'b1;
        tick();
        HREADY = 1'b1;
        chk("t4_htrans_idle", {30'b0, HTRANS}, 0);
        tick();
        HRESP = 1'b0;
        tick(3);
        chk("t4_error", {31'b0, error}, 1);
        chk("t4_fdone_cnt", 32'(obs_fd), 0);
        chk("t4_writes", 32'(obs_acc), 3);
        seen = 0;
        foreach (obs_addr[i]) if (obs_addr[i] == 32'h100C) seen = 1;
        chk("t4_no_100c", {31'b0, seen}, 0);
        clear_obs();
        pulse_start();
        chk("t4_error_cleared", {31'b0, error}, 0);
        wait_evt(3, 1, "t4_fdone");
        tick(3);
        check_full_frame("t4r");

        // Underrun after two words
        clear_obs();
        pulse_start();
        wait_evt(0, 2, "t5_push");
        done = 1'b1; tick(); done = 1'b0;
        tick(3);
        chk("t5_error", {31'b0, error}, 1);
        chk("t5_rfd", {31'b0, ready_for_data}, 0);
        chk("t5_le2_writes", {31'b0, obs_acc <= 2}, 1);
        chk("t5_fdone_cnt", 32'(obs_fd), 0);

        // Reset mid-frame, then a clean frame from BASE
        clear_obs();
        pulse_start();
        wait_evt(2, 2, "t6_acc");
        rst = 1'b1;
        #1;
        chk("t6_htrans", {30'b0, HTRANS}, 0);
        chk("t6_haddr", HADDR, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        clear_obs();
        pulse_start();
        wait_evt(3, 1, "t6_fdone");
        tick(3);
        check_full_frame("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
